elastic_pipe_reg: RTL and testbench
===================================

// Module: elastic_pipe_reg
// PURPOSE
//  Parametrised, handshaked pipeline-stage register with an optional skid slot.
//  It is the successor to the fixed-field stall/flush stage registers.
//  It carries an opaque data payload plus a control field with valid/ready flow control.
//  Flush clears the control field; stall holds the output. Intended between any two pipeline stages.
// PARAMETERS
//  DATA_W   32  payload width (operands, PC, instr); not cleared by flush
//  CTRL_W   8   control width (wren, wb_sel, ...); forced to 0 on reset/flush
//  SKID_EN  1   1: 2-entry skid buffer, s_ready registered; 0: single entry, s_ready combinational
// PORTS
//  i_clk       in   1       clock, all state on rising edge
//  i_rst_n     in   1       synchronous, active-low reset
//  i_stall     in   1       hold: output side treated as m_ready=0
//  i_flush     in   1       discard all held and incoming entries
//  s_valid     in   1       upstream entry valid
//  s_ready     out  1       stage can accept this cycle
//  s_data      in   DATA_W  upstream payload
//  s_ctrl      in   CTRL_W  upstream control
//  m_valid     out  1       downstream entry valid
//  m_ready     in   1       downstream accepts
//  m_data      out  DATA_W  payload to next stage
//  m_ctrl      out  CTRL_W  control to next stage; 0 whenever m_valid=0
//  o_occ       out  2       entries held (0..2; max 1 if SKID_EN=0)
// BEHAVIOUR
//  - Reset (i_rst_n=0 at edge): m_valid=0, m_data=0, m_ctrl=0, o_occ=0; s_ready=0 while reset is low, 1 on the first cycle after release.
//  - acc = s_valid & s_ready; drn = m_valid & m_ready & ~i_stall.
//  - Latency: an entry accepted at edge N is on m_* after edge N. Throughput is 1 entry/cycle.
//  - FSM (SKID_EN=1): EMPTY, MAIN (main valid), FULL (main+skid valid).
//    EMPTY: acc -> MAIN.
//    MAIN: acc&~drn -> FULL (input to skid); acc&drn -> MAIN (input to main); ~acc&drn -> EMPTY.
//    FULL: drn -> MAIN (skid moves to main); s_ready=0.
//    s_ready = (state!=FULL), taken from a register; no m_ready->s_ready comb path.
//  - SKID_EN=0: s_ready = ~m_valid | drn (combinational); the FSM collapses to EMPTY/MAIN.
//  - Ordering: strictly FIFO; the skid entry never overtakes main.
//  - i_flush: highest priority after reset, above stall. Next state is EMPTY, m_valid=0, m_ctrl=0, m_data held.
//    An acc in the flush cycle is discarded.
//  - i_stall without flush: m_* held bit-exact. Accepts continue while space remains (skid fills).
//  - m_ctrl is zeroed in every cycle m_valid=0, so a bubble never writes state downstream.
//  - Payload is held when empty (no toggling). Only ctrl is cleared.
//  - o_occ is registered and equals the FSM encoding: EMPTY=0, MAIN=1, FULL=2.
// STRUCTURE
//  - pipe_pkg: typedef enum logic[1:0] {ST_EMPTY, ST_MAIN, ST_FULL} pipe_st_e.
//    Parameter defaults also go in pipe_pkg.
//  - Sub-module pipe_slot (DATA_W, CTRL_W): one data+ctrl register with load/clear/hold.
//    It is instantiated as main and skid (skid only if SKID_EN). FSM and handshake stay in the top.
// TESTING
//  1. Reset held 3 cycles, then stream of s_data=1,2,3,4 with m_ready=1 -> m_data=1,2,3,4 one cycle later each.
//     m_valid continuous, o_occ=1.
//  2. SKID_EN=1, MAIN holding 0xA, m_ready=0, s_data=0xB accepted -> o_occ=2, s_ready=0.
//     Then m_ready=1 -> m_data 0xA then 0xB, no loss or duplicate.
//  3. FULL, i_flush=1 with s_valid=1 -> next cycle m_valid=0, m_ctrl=0, o_occ=0, s_ready=1.
//     The flushed-cycle input never appears.
//  4. i_stall=1 and i_flush=1 together with MAIN valid (ctrl=0xFF) -> flush wins: m_valid=0, m_ctrl=0.
//  5. i_stall=1 for 5 cycles, m_ready=1, m_data=0x55 -> m_data stays 0x55 and m_valid stays 1.
//     Skid fills with one entry, then s_ready=0.
//  6. Reset asserted while FULL -> after the edge m_valid=0, o_occ=0, m_ctrl=0.
//     Repeat 1-3 with SKID_EN=0 and check s_ready = ~m_valid | drn.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and parameter defaults for the elastic pipeline-stage register.
package pipe_pkg;

    localparam int PIPE_DATA_W_DEF  = 32;
    localparam int PIPE_CTRL_W_DEF  = 8;
    localparam int PIPE_SKID_EN_DEF = 1;

    // The encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MAIN  = 2'd1,
        ST_FULL  = 2'd2
    } pipe_st_e;

    // Occupancy (number of entries held) for a given state.
    function automatic logic [1:0] pipe_occ(input pipe_st_e st);
        return 2'(st);
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload+control register. A load captures both fields. A clear zeroes
// only the control field, so the payload holds its last value and does not
// toggle while the slot is empty.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W_DEF,
    parameter int CTRL_W = PIPE_CTRL_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl
);

    logic [DATA_W-1:0] data_q, data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    // Next-state selection: clear beats load, otherwise hold.
    always_comb begin
        data_d = data_q;
        ctrl_d = ctrl_q;
        if (i_clear) begin
            ctrl_d = '0;
        end else if (i_load) begin
            data_d = i_data;
            ctrl_d = i_ctrl;
        end
    end

    // Slot register with synchronous active-low reset clearing both fields.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            data_q <= '0;
            ctrl_q <= '0;
        end else begin
            data_q <= data_d;
            ctrl_q <= ctrl_d;
        end
    end

    assign o_data = data_q;
    assign o_ctrl = ctrl_q;

endmodule

// File: rtl/elastic_pipe_reg.sv
// Handshaked pipeline-stage register with an optional skid slot.
// The main slot always drives m_*. The skid slot only catches an entry
// accepted while main is stalled. This lets s_ready come from registered
// state instead of combinationally from m_ready.
module elastic_pipe_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W  = PIPE_DATA_W_DEF,
    parameter int CTRL_W  = PIPE_CTRL_W_DEF,
    parameter int SKID_EN = PIPE_SKID_EN_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic [CTRL_W-1:0] s_ctrl,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CTRL_W-1:0] m_ctrl,
    output logic [1:0]        o_occ
);

    pipe_st_e state_q, state_d;

    logic acc;
    logic drn;

    logic              main_load, main_clear;
    logic              skid_load, skid_clear;
    logic [DATA_W-1:0] main_data_d;
    logic [CTRL_W-1:0] main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, skid_data_q;
    logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;

    assign m_valid = (state_q != ST_EMPTY);
    assign drn     = m_valid & m_ready & ~i_stall;
    assign acc     = s_valid & s_ready;

    generate
        if (SKID_EN != 0) begin : g_ready_reg
            // Depends only on the state register. Reset gating keeps it low while reset is held.
            assign s_ready = i_rst_n & (state_q != ST_FULL);
        end else begin : g_ready_comb
            // A single entry can only be replaced when it leaves in the same cycle.
            assign s_ready = i_rst_n & (~m_valid | drn);
        end
    endgenerate

    // Next state and slot control. Flush overrides stall and handshake.
    always_comb begin
        state_d     = state_q;
        main_load   = 1'b0;
        main_clear  = 1'b0;
        skid_load   = 1'b0;
        skid_clear  = 1'b0;
        main_data_d = s_data;
        main_ctrl_d = s_ctrl;
        if (i_flush) begin
            state_d    = ST_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        state_d   = ST_MAIN;
                        main_load = 1'b1;
                    end
                end
                ST_MAIN: begin
                    if (acc && drn) begin
                        main_load = 1'b1;
                    end else if (acc) begin
                        // Main is blocked, so the newcomer waits behind it in skid.
                        if (SKID_EN != 0) begin
                            state_d   = ST_FULL;
                            skid_load = 1'b1;
                        end
                    end else if (drn) begin
                        state_d    = ST_EMPTY;
                        main_clear = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (drn) begin
                        // The older skid entry moves up, preserving FIFO order.
                        state_d     = ST_MAIN;
                        main_load   = 1'b1;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        skid_clear  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (main_load),
        .i_clear (main_clear),
        .i_data  (main_data_d),
        .i_ctrl  (main_ctrl_d),
        .o_data  (main_data_q),
        .o_ctrl  (main_ctrl_q)
    );

    generate
        if (SKID_EN != 0) begin : g_skid
            pipe_slot #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_skid (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_load  (skid_load),
                .i_clear (skid_clear),
                .i_data  (s_data),
                .i_ctrl  (s_ctrl),
                .o_data  (skid_data_q),
                .o_ctrl  (skid_ctrl_q)
            );
        end else begin : g_no_skid
            assign skid_data_q = '0;
            assign skid_ctrl_q = '0;
        end
    endgenerate

    assign m_data = main_data_q;
    assign m_ctrl = main_ctrl_q;
    assign o_occ  = pipe_occ(state_q);

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Self-checking bench for elastic_pipe_reg. It runs one instance with a skid slot
// and one without, fed from the same stimulus. Each instance is checked against
// its own queue model on every cycle. Literal expectations pin the directed cases.
module tb_elastic_pipe_reg;

    localparam int DW = 32;
    localparam int CW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, stall, flush, s_valid, m_ready;
    logic [DW-1:0] s_data;
    logic [CW-1:0] s_ctrl;

    logic          a_s_ready, a_m_valid, b_s_ready, b_m_valid;
    logic [DW-1:0] a_m_data, b_m_data;
    logic [CW-1:0] a_m_ctrl, b_m_ctrl;
    logic [1:0]    a_occ, b_occ;

    elastic_pipe_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1)) dut_skid (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_flush(flush),
        .s_valid(s_valid), .s_ready(a_s_ready), .s_data(s_data), .s_ctrl(s_ctrl),
        .m_valid(a_m_valid), .m_ready(m_ready), .m_data(a_m_data), .m_ctrl(a_m_ctrl),
        .o_occ(a_occ)
    );

    elastic_pipe_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(0)) dut_noskid (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_flush(flush),
        .s_valid(s_valid), .s_ready(b_s_ready), .s_data(s_data), .s_ctrl(s_ctrl),
        .m_valid(b_m_valid), .m_ready(m_ready), .m_data(b_m_data), .m_ctrl(b_m_ctrl),
        .o_occ(b_occ)
    );

    int tests = 0;
    int fails = 0;

    // Model: per instance (0 = skid, 1 = no skid) a small FIFO plus the last payload shown.
    int            cnt [2];
    logic [DW-1:0] fd [2][2];
    logic [CW-1:0] fc [2][2];
    logic [DW-1:0] shown [2];
    bit            started = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic bit mdl_drn(input int k);
        return (cnt[k] > 0) && (m_ready === 1'b1) && (stall === 1'b0);
    endfunction

    function automatic bit mdl_srdy(input int k);
        if (rst_n !== 1'b1) return 1'b0;
        if (k == 0) return cnt[k] < 2;
        return (cnt[k] == 0) || mdl_drn(k);
    endfunction

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            logic          mv, sr;
            logic [DW-1:0] md;
            logic [CW-1:0] mc;
            logic [1:0]    oc;
            if (k == 0) begin
                mv = a_m_valid; md = a_m_data; mc = a_m_ctrl; oc = a_occ; sr = a_s_ready;
            end else begin
                mv = b_m_valid; md = b_m_data; mc = b_m_ctrl; oc = b_occ; sr = b_s_ready;
            end
            chk($sformatf("inst%0d m_valid", k), 64'(mv), 64'(cnt[k] > 0));
            chk($sformatf("inst%0d m_data", k), 64'(md), 64'((cnt[k] > 0) ? fd[k][0] : shown[k]));
            chk($sformatf("inst%0d m_ctrl", k), 64'(mc), 64'((cnt[k] > 0) ? fc[k][0] : '0));
            chk($sformatf("inst%0d o_occ", k), 64'(oc), 64'(cnt[k]));
            chk($sformatf("inst%0d s_ready", k), 64'(sr), 64'(mdl_srdy(k)));
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            bit d, a;
            d = mdl_drn(k);
            a = (s_valid === 1'b1) && mdl_srdy(k);
            if (rst_n !== 1'b1) begin
                cnt[k]   = 0;
                shown[k] = '0;
            end else if (flush === 1'b1) begin
                cnt[k] = 0;
            end else begin
                if (d) begin
                    fd[k][0] = fd[k][1];
                    fc[k][0] = fc[k][1];
                    cnt[k]--;
                end
                if (a) begin
                    fd[k][cnt[k]] = s_data;
                    fc[k][cnt[k]] = s_ctrl;
                    cnt[k]++;
                end
                if (cnt[k] > 0) shown[k] = fd[k][0];
            end
        end
    endtask

    // One clock: compare at the falling edge, advance the model, return 1 time unit after the rising edge.
    task automatic step();
        @(negedge clk);
        if (started) compare_all();
        model_update();
        if (rst_n !== 1'b1) started = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        s_data = '0; s_ctrl = '0;

        // Reset held for three cycles.
        repeat (3) step();
        chk("reset m_valid", 64'(a_m_valid), 64'(0));
        chk("reset m_data", 64'(a_m_data), 64'(0));
        chk("reset o_occ", 64'(a_occ), 64'(0));
        chk("reset s_ready skid", 64'(a_s_ready), 64'(0));
        chk("reset s_ready noskid", 64'(b_s_ready), 64'(0));

        // Streaming at full rate.
        rst_n = 1'b1; m_ready = 1'b1;
        #1;
        chk("release s_ready skid", 64'(a_s_ready), 64'(1));
        chk("release s_ready noskid", 64'(b_s_ready), 64'(1));
        for (int i = 1; i <= 4; i++) begin
            s_valid = 1'b1; s_data = DW'(i); s_ctrl = CW'(16 + i);
            step();
            chk("stream m_data skid", 64'(a_m_data), 64'(i));
            chk("stream m_valid skid", 64'(a_m_valid), 64'(1));
            chk("stream o_occ skid", 64'(a_occ), 64'(1));
            chk("stream m_data noskid", 64'(b_m_data), 64'(i));
        end
        s_valid = 1'b0;
        step();

        // Skid fill with downstream blocked, then drain in order.
        m_ready = 1'b0; s_valid = 1'b1; s_data = 'hA; s_ctrl = 'h1A;
        step();
        chk("skid main occ", 64'(a_occ), 64'(1));
        s_data = 'hB; s_ctrl = 'h1B;
        step();
        chk("skid full occ", 64'(a_occ), 64'(2));
        chk("skid full s_ready", 64'(a_s_ready), 64'(0));
        chk("skid full m_data", 64'(a_m_data), 64'('hA));
        chk("noskid blocked occ", 64'(b_occ), 64'(1));
        chk("noskid blocked s_ready", 64'(b_s_ready), 64'(0));
        s_valid = 1'b0; m_ready = 1'b1;
        #1;
        chk("noskid drn s_ready", 64'(b_s_ready), 64'(1));
        step();
        chk("skid drain second data", 64'(a_m_data), 64'('hB));
        chk("skid drain second ctrl", 64'(a_m_ctrl), 64'('h1B));
        chk("skid drain occ", 64'(a_occ), 64'(1));
        step();
        chk("empty m_valid", 64'(a_m_valid), 64'(0));
        chk("empty m_ctrl", 64'(a_m_ctrl), 64'(0));
        chk("empty m_data held", 64'(a_m_data), 64'('hB));

        // Flush while full, with an incoming entry that must be discarded.
        m_ready = 1'b0; s_valid = 1'b1; s_data = 'hC; s_ctrl = 'h2C;
        step();
        s_data = 'hD; s_ctrl = 'h2D;
        step();
        chk("pre-flush occ", 64'(a_occ), 64'(2));
        flush = 1'b1; s_data = 'hE; s_ctrl = 'h2E;
        step();
        flush = 1'b0; s_valid = 1'b0;
        chk("flush m_valid", 64'(a_m_valid), 64'(0));
        chk("flush m_ctrl", 64'(a_m_ctrl), 64'(0));
        chk("flush o_occ", 64'(a_occ), 64'(0));
        chk("flush s_ready", 64'(a_s_ready), 64'(1));
        chk("flush m_data held", 64'(a_m_data), 64'('hC));
        chk("flush noskid m_valid", 64'(b_m_valid), 64'(0));
        m_ready = 1'b1;
        repeat (2) begin
            step();
            chk("post-flush no ghost", 64'(a_m_valid), 64'(0));
        end

        // Flush and stall together: flush wins.
        m_ready = 1'b0; s_valid = 1'b1; s_data = 'h77; s_ctrl = 'hFF;
        step();
        chk("main ctrl FF", 64'(a_m_ctrl), 64'('hFF));
        s_valid = 1'b0; stall = 1'b1; flush = 1'b1;
        step();
        stall = 1'b0; flush = 1'b0;
        chk("stall+flush m_valid", 64'(a_m_valid), 64'(0));
        chk("stall+flush m_ctrl", 64'(a_m_ctrl), 64'(0));
        chk("stall+flush noskid m_ctrl", 64'(b_m_ctrl), 64'(0));

        // Stall holds the output while the skid slot fills.
        m_ready = 1'b1; s_valid = 1'b1; s_data = 'h55; s_ctrl = 'h05;
        step();
        stall = 1'b1; s_data = 'h66; s_ctrl = 'h06;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall m_data skid", 64'(a_m_data), 64'('h55));
            chk("stall m_valid skid", 64'(a_m_valid), 64'(1));
            chk("stall m_data noskid", 64'(b_m_data), 64'('h55));
        end
        chk("stall occ", 64'(a_occ), 64'(2));
        chk("stall s_ready skid", 64'(a_s_ready), 64'(0));
        chk("stall s_ready noskid", 64'(b_s_ready), 64'(0));
        stall = 1'b0; s_valid = 1'b0;
        step();
        chk("post-stall m_data", 64'(a_m_data), 64'('h66));
        repeat (2) step();

        // Reset while full.
        m_ready = 1'b0; s_valid = 1'b1; s_data = 'h91; s_ctrl = 'h31;
        step();
        s_data = 'h92; s_ctrl = 'h32;
        step();
        chk("pre-reset occ", 64'(a_occ), 64'(2));
        s_valid = 1'b0; rst_n = 1'b0;
        step();
        chk("reset-full m_valid", 64'(a_m_valid), 64'(0));
        chk("reset-full o_occ", 64'(a_occ), 64'(0));
        chk("reset-full m_ctrl", 64'(a_m_ctrl), 64'(0));
        chk("reset-full s_ready", 64'(a_s_ready), 64'(0));
        rst_n = 1'b1;

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            s_valid = ($urandom_range(0, 99) < 70);
            m_ready = ($urandom_range(0, 99) < 60);
            stall   = ($urandom_range(0, 99) < 10);
            flush   = ($urandom_range(0, 99) < 3);
            rst_n   = !($urandom_range(0, 199) < 1);
            s_data  = $urandom;
            s_ctrl  = CW'($urandom);
            step();
        end

        rst_n = 1'b1; s_valid = 1'b0; m_ready = 1'b1; stall = 1'b0; flush = 1'b0;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
